// File: rtl/snapshot_collector.sv
// snapshot_collector: assembles tagged I/Q beats into an 8-antenna + desired snapshot for an LMS core
// Ports: clk; rst_n async active-low; s_valid/s_ready/s_tag/s_data upstream beats (tag 0..7 antennas, 8 desired);
// hold defers the final commit; xin1..xin8/din registered snapshot; snap_valid one-cycle commit pulse;
// drop_cnt saturating count of discarded partial snapshots, built only when SNAPSHOT_COLLECTOR_DROP_CNT_EN is defined.
module snapshot_collector #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [3:0]   s_tag,
  input  logic [W-1:0] s_data,
  input  logic         hold,
  output logic [W-1:0] xin1,
  output logic [W-1:0] xin2,
  output logic [W-1:0] xin3,
  output logic [W-1:0] xin4,
  output logic [W-1:0] xin5,
  output logic [W-1:0] xin6,
  output logic [W-1:0] xin7,
  output logic [W-1:0] xin8,
  output logic [W-1:0] din,
  output logic         snap_valid,
  output logic [15:0]  drop_cnt
);
  logic [W-1:0] shadow [9];
  logic [W-1:0] xout [9];
  logic [3:0] idx;
  logic pending, acc, hit, last, commit;
  assign s_ready = rst_n & ~pending;
  assign acc = s_valid & s_ready;
  assign hit = s_tag == idx;
  assign last = acc & hit & (idx == 4'd8);
  // commit straight from the desired beat, or later from the parked copy once hold drops
  assign commit = (last | pending) & ~hold;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      pending <= 1'b0;
      snap_valid <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        shadow[i] <= '0;
        xout[i] <= '0;
      end
    end else begin
      snap_valid <= commit;
      if (commit) begin
        for (int i = 0; i < 8; i++) xout[i] <= shadow[i];
        xout[8] <= pending ? shadow[8] : s_data;
        pending <= 1'b0;
        idx <= '0;
      end else if (last) begin
        shadow[8] <= s_data;
        pending <= 1'b1;
      end else if (acc & hit) begin
        shadow[idx] <= s_data;
        idx <= idx + 4'd1;
      end else if (acc) begin
        // out-of-order beat: a tag 0 restarts the snapshot, anything else waits for one
        if (s_tag == 4'd0) shadow[0] <= s_data;
        idx <= (s_tag == 4'd0) ? 4'd1 : 4'd0;
      end
    end
  assign xin1 = xout[0];
  assign xin2 = xout[1];
  assign xin3 = xout[2];
  assign xin4 = xout[3];
  assign xin5 = xout[4];
  assign xin6 = xout[5];
  assign xin7 = xout[6];
  assign xin8 = xout[7];
  assign din  = xout[8];
`ifdef SNAPSHOT_COLLECTOR_DROP_CNT_EN
  logic [15:0] drop_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_q <= '0;
    else if (acc && !hit && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_snapshot_collector.sv
// tb_snapshot_collector: scoreboard bench for snapshot_collector
module tb_snapshot_collector;
  localparam int W = 36;
  localparam logic [W-1:0] BASE = 36'h000010001;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [3:0] s_tag = '0;
  logic [W-1:0] s_data = '0;
  logic hold = 1'b0;
  logic [W-1:0] xin1, xin2, xin3, xin4, xin5, xin6, xin7, xin8, din;
  logic snap_valid;
  logic [15:0] drop_cnt;
  logic [9*W-1:0] ov, last_exp;
  logic [9*W-1:0] sb [$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_drop = 0;
  snapshot_collector #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_tag(s_tag), .s_data(s_data),
    .hold(hold), .xin1(xin1), .xin2(xin2), .xin3(xin3), .xin4(xin4), .xin5(xin5), .xin6(xin6),
    .xin7(xin7), .xin8(xin8), .din(din), .snap_valid(snap_valid), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  assign ov = {din, xin8, xin7, xin6, xin5, xin4, xin3, xin2, xin1};
  task automatic chk(input string tag, input logic [9*W-1:0] got, input logic [9*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] dat(input int k, input logic [W-1:0] salt);
    logic [W-1:0] b;
    b = BASE * (W)'(k + 1);
    return b ^ salt;
  endfunction
  function automatic logic [9*W-1:0] vec(input logic [W-1:0] salt);
    logic [9*W-1:0] v;
    for (int k = 0; k < 9; k++) v[k*W +: W] = dat(k, salt);
    return v;
  endfunction
  function automatic void note_drop();
    if (exp_drop != 65535) exp_drop++;
  endfunction
  function automatic logic [15:0] drop_exp();
`ifdef SNAPSHOT_COLLECTOR_DROP_CNT_EN
    return 16'(exp_drop);
`else
    return 16'd0;
`endif
  endfunction
  always @(negedge clk)
    if (snap_valid) begin
      if (sb.size() == 0) chk("unexpected_snap", 1, 0);
      else chk("snap", ov, sb.pop_front());
    end
  task automatic send(input logic [3:0] t, input logic [W-1:0] d);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_tag = t;
    s_data = d;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask
  task automatic seq(input logic [W-1:0] salt);
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin
        sb.push_back(vec(salt));
        last_exp = vec(salt);
      end
      send(4'(k), dat(k, salt));
    end
  endtask
  task automatic bad(input int n);
    for (int i = 0; i < n; i++) begin
      send(4'($urandom_range(15, 9)), W'($urandom));
      note_drop();
    end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [W-1:0] salt;
    last_exp = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", ov, '0);
    chk("rst_ready", s_ready, 0);
    chk("rst_snap", snap_valid, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", s_ready, 1);
    // plain in-order snapshot
    seq('0);
    @(negedge clk);
    chk("drop_clean", drop_cnt, drop_exp());
    // 0,1,2 then restart at 0: tag-0 beat resyncs
    salt = 36'h8_0000_1234;
    for (int k = 0; k < 3; k++) send(4'(k), dat(k, 36'h3_3333_3333));
    note_drop();
    seq(salt);
    chk("resync_drop", drop_cnt, drop_exp());
    // illegal tag on first beat
    bad(1);
    chk("tag12_drop", drop_cnt, drop_exp());
    chk("tag12_hold_out", ov, last_exp);
    seq(36'h5_A5A5_5A5A);
    // nonzero mismatch mid-snapshot
    for (int k = 0; k < 4; k++) send(4'(k), dat(k, 36'h1_1111_1111));
    send(4'd6, '1);
    note_drop();
    chk("mid_drop", drop_cnt, drop_exp());
    seq(36'hF_0F0F_F0F0);
    // hold during the whole snapshot, then 5 frozen cycles
    salt = 36'hC_DEAD_BEEF;
    hold = 1'b1;
    for (int k = 0; k < 9; k++) send(4'(k), dat(k, salt));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("pend_ready", s_ready, 0);
      chk("pend_out", ov, last_exp);
      chk("pend_snap", snap_valid, 0);
    end
    sb.push_back(vec(salt));
    last_exp = vec(salt);
    hold = 1'b0;
    @(negedge clk);
    chk("commit_pulse", snap_valid, 1);
    chk("ready_after_commit", s_ready, 1);
    @(negedge clk);
    chk("pulse_one_cycle", snap_valid, 0);
    // async reset mid-snapshot
    for (int k = 0; k < 5; k++) send(4'(k), dat(k, 36'h7_7777_7777));
    #2 rst_n = 1'b0;
    #1;
    chk("async_out", ov, '0);
    chk("async_snap", snap_valid, 0);
    chk("async_drop", drop_cnt, 0);
    chk("async_ready", s_ready, 0);
    exp_drop = 0;
    last_exp = '0;
    @(negedge clk);
    chk("rst_no_snap", snap_valid, 0);
    rst_n = 1'b1;
    seq(36'h2_4681_3579);
    // saturating drop counter
    bad(300);
    chk("drop_300", drop_cnt, drop_exp());
    bad(65535 - 300);
    chk("drop_max", drop_cnt, drop_exp());
    bad(5);
    chk("drop_sat", drop_cnt, drop_exp());
    chk("sat_out", ov, last_exp);
    seq(36'h9_1357_2468);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/snapshot_collector.md
SNAPSHOT_COLLECTOR -- requirements
Module: snapshot_collector

Interface
REQ-001 SHALL have parameter W, default 36, packed sample width {I[W/2-1:0], Q[W/2-1:0]}; W SHALL be even.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_valid  input  1  upstream beat valid.
REQ-005 SHALL have port s_ready  output  1  collector can accept a beat.
REQ-006 SHALL have port s_tag  input  4  beat source: 0..7 = antenna 1..8, 8 = desired reference, 9..15 illegal.
REQ-007 SHALL have port s_data  input  W  signed packed I/Q sample.
REQ-008 SHALL have port hold  input  1  downstream LMS core requests frozen outputs.
REQ-009 SHALL have ports xin1..xin8  output  W each  registered antenna snapshot for the LMS core.
REQ-010 SHALL have port din  output  W  registered desired sample for the LMS core.
REQ-011 SHALL have port snap_valid  output  1  one-cycle pulse: new snapshot on xin1..xin8/din.
REQ-012 SHALL have port drop_cnt  output  16  count of discarded partial snapshots.

Function
REQ-013 Beat SHALL be accepted on a rising edge where s_valid=1 and s_ready=1; no other edge changes assembly state.
REQ-014 Expected-index counter idx (0..8) SHALL require tags in strict order 0,1,...,7,8 per snapshot.
REQ-015 Accepted beat with s_tag==idx SHALL be written to shadow slot idx and idx SHALL increment.
REQ-016 Accepted beat with s_tag!=idx SHALL discard the partial snapshot and increment drop_cnt (saturating at 65535).
REQ-017 On a mismatch, a beat with s_tag==0 SHALL be kept as slot 0 (idx->1); any other tag SHALL be dropped (idx->0).
REQ-018 Mismatch with idx==0 and tag!=0 SHALL count as one drop.
REQ-019 Accepting tag 8 with idx==8 and hold=0 SHALL, on that same edge, load shadow slots 0..7 and s_data into xin1..xin8 and din, set idx->0, and set snap_valid=1 for exactly the following cycle.
REQ-020 Accepting tag 8 with idx==8 and hold=1 SHALL store the beat, set pending=1, and leave outputs unchanged.
REQ-021 While pending=1, s_ready SHALL be 0; s_ready SHALL be 1 otherwise.
REQ-022 First edge with pending=1 and hold=0 SHALL commit the shadow snapshot to outputs, clear pending, set idx->0, and pulse snap_valid for one cycle.
REQ-023 hold SHALL NOT affect acceptance of beats for slots 0..7; only the final commit waits on hold.
REQ-024 Outputs xin1..xin8/din SHALL change only on a commit edge; they SHALL hold values across all other cycles.
REQ-025 Data SHALL pass unmodified (no rounding, saturation or I/Q swap); min latency from desired-beat acceptance to valid outputs is 0 edges (same edge), snap_valid visible next cycle.

Reset
REQ-026 rst_n=0 SHALL immediately clear xin1..xin8, din, snap_valid, drop_cnt, idx, pending and all shadow slots to 0.
REQ-027 s_ready SHALL be 0 while rst_n=0 and 1 from the first cycle after release.
REQ-028 Reset mid-snapshot or while pending SHALL discard the partial or pending snapshot without a snap_valid pulse or drop count.

Configuration
REQ-029 Macro SNAPSHOT_COLLECTOR_DROP_CNT_EN defined: drop_cnt SHALL operate per REQ-016.
REQ-030 Macro absent: drop_cnt SHALL be constant 0 and no counter logic SHALL be built; resync behaviour (REQ-016/017) SHALL be unchanged.

Verification
REQ-031 In-order tags 0..8, data 0x000010001..0x000090009, hold=0 -> xin1=0x000010001 ... din=0x000090009 and one snap_valid pulse.
REQ-032 Tags 0,1,2,0,1,...,8 -> drop_cnt=1, second sequence delivered intact, one snap_valid.
REQ-033 Tags 0..7, then tag 8 with hold=1 for 5 cycles -> s_ready=0 for 5 cycles, outputs unchanged; commit and snap_valid on first hold=0 edge.
REQ-034 Tag 12 on the first beat -> drop_cnt=1, idx stays 0, no output change.
REQ-035 rst_n asserted after tag 4 -> all outputs 0 asynchronously, no snap_valid; full sequence after release completes normally.
REQ-036 300 consecutive mismatched beats with macro defined -> drop_cnt=300; 70000 mismatches -> drop_cnt=65535; macro absent -> drop_cnt=0.
